// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_param
// Purpose  : Parametrised UART transmitter. Serialises DATA_W-bit words LSB
//            first with start bit, optional parity and one or two stop bits.
//            Words wait in a transmit queue so trmt strobes can be issued
//            back-to-back without watching tx_done.
// Options  : UART_TX_FIFO_EN defined   -> FIFO_DEPTH-entry transmit FIFO
//            UART_TX_FIFO_EN undefined -> single holding register
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
  parameter int DATA_W     = 8,
  parameter int BAUD_DIV   = 5208,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trmt,
  input  logic [DATA_W-1:0] tx_data,
  output logic              TX,
  output logic              tx_done,
  output logic              busy,
  output logic              tx_full,
  output logic              overrun
);

  localparam int              c_BW        = $clog2(BAUD_DIV);
  localparam int              c_NW        = $clog2(DATA_W);
  localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(BAUD_DIV - 1);
  localparam logic [c_NW-1:0] c_BIT_LAST  = c_NW'(DATA_W - 1);
  localparam logic            c_STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic            c_PAR_ODD   = (PARITY == 2);

  // Reject illegal configurations at elaboration time.
  if (DATA_W < 5 || DATA_W > 9) begin : g_chk_data_w
    $error("uart_tx_param: DATA_W must be in 5..9");
  end
  if (BAUD_DIV < 4) begin : g_chk_baud
    $error("uart_tx_param: BAUD_DIV must be >= 4");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t            r_state;
  logic [c_BW-1:0]   r_baud;
  logic [c_NW-1:0]   r_bit;
  logic              r_stop;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;

  logic              w_tick;
  logic              w_frame_end;
  logic              w_pop;
  logic              w_push;
  logic              w_empty;
  logic              w_full;
  logic [DATA_W-1:0] w_head;

  assign w_tick      = (r_baud == c_BAUD_LAST);
  assign w_frame_end = (r_state == S_STOP) && w_tick && (r_stop == c_STOP_LAST);
  // The shifter takes a word whenever it is idle or finishing the last stop bit.
  assign w_pop       = !w_empty && ((r_state == S_IDLE) || w_frame_end);
  // Fullness is judged before this edge's pop, so a pop never frees room
  // for a push on the same edge.
  assign w_push      = trmt && !w_full;

  assign busy    = (r_state != S_IDLE) || !w_empty;
  assign tx_full = w_full;

`ifdef UART_TX_FIFO_EN
  localparam int c_AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW:0]     r_wr_ptr;
  logic [c_AW:0]     r_rd_ptr;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                   (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
  assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

  // Queue storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= tx_data;
    end
  end

  // Queue pointers with wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end
`else
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_vld;

  assign w_empty = !r_hold_vld;
  assign w_full  = r_hold_vld;
  assign w_head  = r_hold;

  // Single holding register; frees on the edge its word enters the shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if (w_push) begin
      r_hold     <= tx_data;
      r_hold_vld <= 1'b1;
    end else if (w_pop) begin
      r_hold_vld <= 1'b0;
    end
  end
`endif

  // Flag a strobe that arrived while the queue could not take it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else begin
      overrun <= trmt && w_full;
    end
  end

  // Frame sequencer: drives TX and tx_done from registers, walks the bit slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      TX      <= 1'b1;
      tx_done <= 1'b0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          TX     <= 1'b1;
          r_baud <= '0;
        end
        S_START: begin
          if (w_tick) begin
            r_baud  <= '0;
            TX      <= r_shift[0];
            r_shift <= {1'b0, r_shift[DATA_W-1:1]};
            r_bit   <= '0;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_baud <= '0;
            if (r_bit == c_BIT_LAST) begin
              if (PARITY != 0) begin
                TX      <= r_par;
                r_state <= S_PAR;
              end else begin
                TX      <= 1'b1;
                r_stop  <= 1'b0;
                r_state <= S_STOP;
              end
            end else begin
              TX      <= r_shift[0];
              r_shift <= {1'b0, r_shift[DATA_W-1:1]};
              r_bit   <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_PAR: begin
          if (w_tick) begin
            r_baud  <= '0;
            TX      <= 1'b1;
            r_stop  <= 1'b0;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_baud <= '0;
            if (r_stop == c_STOP_LAST) begin
              tx_done <= 1'b1;
              TX      <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_stop <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          TX      <= 1'b1;
          r_baud  <= '0;
          r_state <= S_IDLE;
        end
      endcase
      // A queued word starts its frame from idle or directly off the last
      // stop bit, overriding the idle transition above so there is no gap.
      if (w_pop) begin
        r_state <= S_START;
        TX      <= 1'b0;
        r_baud  <= '0;
        r_shift <= w_head;
        r_par   <= (^w_head) ^ c_PAR_ODD;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_param
// Purpose  : Self-checking bench for uart_tx_param. Three instances cover
//            8N1, 8O2 and 8E1 framing at a 16-clock bit period; a line
//            monitor per instance decodes frames against a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_param;

  localparam int BAUD = 16;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         clks;
  } sb_t;

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic       par;
    int         clks;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] trmt_v = 3'b000;
  logic [7:0] data_v [3] = '{8'h00, 8'h00, 8'h00};
  logic [2:0] tx_v;
  logic [2:0] done_v;
  logic [2:0] busy_v;
  logic [2:0] full_v;
  logic [2:0] ovr_v;

  int  cyc = 0;
  int  nvec = 0;
  int  nerr = 0;
  bit  mon_en = 1'b1;
  int  done_cnt [3] = '{0, 0, 0};
  int  exp_done [3] = '{0, 0, 0};
  sb_t q0 [$];
  sb_t q1 [$];
  sb_t q2 [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_v[k]) done_cnt[k] <= done_cnt[k] + 1;
    end
  end

  uart_tx_param #(.DATA_W(8), .BAUD_DIV(BAUD), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .trmt(trmt_v[0]), .tx_data(data_v[0]), .TX(tx_v[0]),
    .tx_done(done_v[0]), .busy(busy_v[0]), .tx_full(full_v[0]), .overrun(ovr_v[0]));

  uart_tx_param #(.DATA_W(8), .BAUD_DIV(BAUD), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .trmt(trmt_v[1]), .tx_data(data_v[1]), .TX(tx_v[1]),
    .tx_done(done_v[1]), .busy(busy_v[1]), .tx_full(full_v[1]), .overrun(ovr_v[1]));

  uart_tx_param #(.DATA_W(8), .BAUD_DIV(BAUD), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .trmt(trmt_v[2]), .tx_data(data_v[2]), .TX(tx_v[2]),
    .tx_done(done_v[2]), .busy(busy_v[2]), .tx_full(full_v[2]), .overrun(ovr_v[2]));

  function automatic void chk1(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk32(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void mchk1(input string name, input logic act, input logic exp);
    if (mon_en) chk1(name, act, exp);
  endfunction

  function automatic void mchk32(input string name, input int act, input int exp);
    if (mon_en) chk32(name, act, exp);
  endfunction

  function automatic int sb_size(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic sb_t sb_pop(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void sb_push(input int d, input sb_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  // Called at a negedge; strobes trmt across one rising edge, returns at the next negedge.
  task automatic drive(input int d, input logic [7:0] data, input logic par,
                       input int clks, input bit acc);
    sb_t e;
    trmt_v[d] = 1'b1;
    data_v[d] = data;
    if (acc) begin
      e.data = data;
      e.par  = par;
      e.clks = clks;
      sb_push(d, e);
      exp_done[d]++;
    end
    @(negedge clk);
    trmt_v[d] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy_v != 3'b000) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk1({name, "_idle_in_time"}, n < 4000, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  // Decodes one line: samples at bit centres and checks against the scoreboard.
  task automatic monitor(input int d);
    sb_t e;
    bit  stay = 1'b0;
    bit  seen;
    int  t0;
    int  nstop = (d == 1) ? 2 : 1;
    forever begin
      if (!stay) @(negedge clk);
      stay = 1'b0;
      if (tx_v[d] === 1'b0 && mon_en) begin
        t0 = cyc;
        mchk1($sformatf("frame_expected[%0d]", d), sb_size(d) != 0, 1'b1);
        if (sb_size(d) != 0) begin
          e = sb_pop(d);
        end else begin
          e.data = 8'h00;
          e.par  = 1'b0;
          e.clks = 0;
        end
        repeat (BAUD / 2) @(negedge clk);
        mchk1($sformatf("start_bit[%0d]", d), tx_v[d], 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          mchk1($sformatf("data_bit%0d[%0d] word %h", i, d, e.data), tx_v[d], e.data[i]);
        end
        if (d != 0) begin
          repeat (BAUD) @(negedge clk);
          mchk1($sformatf("parity_bit[%0d] word %h", d, e.data), tx_v[d], e.par);
        end
        for (int s = 0; s < nstop; s++) begin
          repeat (BAUD) @(negedge clk);
          mchk1($sformatf("stop_bit%0d[%0d]", s, d), tx_v[d], 1'b1);
        end
        seen = 1'b0;
        for (int j = 0; j < 40 && !seen; j++) begin
          @(negedge clk);
          if (done_v[d]) seen = 1'b1;
        end
        mchk1($sformatf("tx_done_seen[%0d]", d), seen, 1'b1);
        mchk32($sformatf("frame_clks[%0d]", d), cyc - t0, e.clks);
        if (sb_size(d) != 0) mchk1($sformatf("back_to_back[%0d]", d), tx_v[d], 1'b0);
        stay = 1'b1;
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  initial begin
    vec_t       vecs [11];
    logic [7:0] words [6];
    int         lows;

    vecs[0]  = '{0, 8'h00, 1'b0, 160};
    vecs[1]  = '{0, 8'hFF, 1'b0, 160};
    vecs[2]  = '{0, 8'h3C, 1'b0, 160};
    vecs[3]  = '{1, 8'h07, 1'b0, 192};
    vecs[4]  = '{1, 8'h00, 1'b1, 192};
    vecs[5]  = '{1, 8'hFF, 1'b1, 192};
    vecs[6]  = '{1, 8'h80, 1'b0, 192};
    vecs[7]  = '{2, 8'h07, 1'b1, 176};
    vecs[8]  = '{2, 8'h00, 1'b0, 176};
    vecs[9]  = '{2, 8'h81, 1'b0, 176};
    vecs[10] = '{2, 8'h01, 1'b1, 176};
    words    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hEE};

    // Reset values, held and after release.
    repeat (3) @(negedge clk);
    chk1("rst_TX", tx_v[0], 1'b1);
    chk1("rst_tx_done", done_v[0], 1'b0);
    chk1("rst_busy", busy_v[0], 1'b0);
    chk1("rst_tx_full", full_v[0], 1'b0);
    chk1("rst_overrun", ovr_v[0], 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk32("post_rst_lines_idle", int'(tx_v), 7);
    chk32("post_rst_busy", int'(busy_v), 0);

    // First-frame latency on 8N1 with 0xA5.
    drive(0, 8'hA5, 1'b0, 160, 1'b1);
    chk1("lat_busy_edge_k", busy_v[0], 1'b1);
    chk1("lat_TX_edge_k", tx_v[0], 1'b1);
    @(negedge clk);
    chk1("lat_TX_edge_k1", tx_v[0], 1'b0);
    wait_idle("frame_a5");

    // Table of single frames across the three framings.
    for (int v = 0; v < 11; v++) begin
      drive(vecs[v].dut, vecs[v].data, vecs[v].par, vecs[v].clks, 1'b1);
      wait_idle($sformatf("vec%0d", v));
      chk1($sformatf("vec%0d_line_idle", v), tx_v[vecs[v].dut], 1'b1);
    end
    for (int d = 0; d < 3; d++) chk32($sformatf("done_count_table[%0d]", d), done_cnt[d], exp_done[d]);

`ifdef UART_TX_FIFO_EN
    // Five consecutive strobes fill shifter + 4-entry FIFO, sixth overruns.
    for (int i = 0; i < 5; i++) drive(0, words[i], 1'b0, 160, 1'b1);
    chk1("fifo_full", full_v[0], 1'b1);
    chk1("overrun_before", ovr_v[0], 1'b0);
    drive(0, words[5], 1'b0, 160, 1'b0);
    chk1("overrun_pulse", ovr_v[0], 1'b1);
    @(negedge clk);
    chk1("overrun_one_cycle", ovr_v[0], 1'b0);
    chk1("fifo_still_full", full_v[0], 1'b1);
`else
    // One word loads into the shifter, the next waits in the holding
    // register, and a further strobe while it is occupied overruns.
    drive(0, words[0], 1'b0, 160, 1'b1);
    @(negedge clk);
    chk1("hold_freed_on_load", full_v[0], 1'b0);
    drive(0, words[1], 1'b0, 160, 1'b1);
    chk1("hold_full", full_v[0], 1'b1);
    chk1("overrun_before", ovr_v[0], 1'b0);
    drive(0, words[2], 1'b0, 160, 1'b0);
    chk1("overrun_pulse", ovr_v[0], 1'b1);
    @(negedge clk);
    chk1("overrun_one_cycle", ovr_v[0], 1'b0);
    chk1("hold_still_full", full_v[0], 1'b1);
`endif
    wait_idle("queue_burst");
    chk32("done_count_queue", done_cnt[0], exp_done[0]);
    chk1("queue_drained", full_v[0], 1'b0);

    // Reset in the middle of DATA with a word still queued.
    mon_en = 1'b0;
    drive(0, 8'h00, 1'b0, 0, 1'b0);
    @(negedge clk);
    drive(0, 8'h00, 1'b0, 0, 1'b0);
    repeat (3 * BAUD) @(negedge clk);
    chk1("pre_rst_TX_low", tx_v[0], 1'b0);
    chk1("pre_rst_busy", busy_v[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("mid_rst_TX_async", tx_v[0], 1'b1);
    chk1("mid_rst_busy", busy_v[0], 1'b0);
    chk1("mid_rst_tx_full", full_v[0], 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1) lows++;
    end
    chk32("after_rst_line_idle", lows, 0);
    chk32("after_rst_no_done", done_cnt[0], exp_done[0]);
    chk1("after_rst_busy", busy_v[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
